// File: rtl/xor3_bist_pkg.sv
// Shared definitions for the xor3 BIST controller: FSM states, vector sizing
// and the golden model of the 3-input XOR under test.
package xor3_bist_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // Odd parity of {a,b,c}: the value a healthy gate must produce.
    function automatic logic expected_f(input logic [VEC_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/xor3_settle_timer.sv
// Loadable down-counter that times how long each vector is held on the gate
// before its output is sampled.
module xor3_settle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/xor3_bist_ctrl.sv
// BIST controller for an external 3-input XOR: walks all eight input vectors,
// checks the gate output against odd parity and records the outcome.
module xor3_bist_ctrl
    import xor3_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    input  logic             dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_count,
    output logic [VEC_W-1:0] first_fail,
    output logic             first_fail_valid
);

    localparam int               TIMER_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    bist_state_e      state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [3:0]       err_q, err_d;
    logic [VEC_W-1:0] ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic             pass_q, pass_d;
    logic             timer_load;
    logic             timer_expired;
    logic             mismatch;

    xor3_settle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (LOAD_VAL),
        .expired_o  (timer_expired)
    );

    assign mismatch = (dut_f != expected_f(vec_q));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        vec_d      = vec_q;
        err_d      = err_q;
        ff_d       = ff_q;
        ffv_d      = ffv_q;
        pass_d     = pass_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_APPLY;
                    vec_d      = '0;
                    err_d      = '0;
                    ff_d       = '0;
                    ffv_d      = 1'b0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_APPLY: begin
                if (timer_expired) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    if (!ffv_q) begin
                        ff_d  = vec_q;
                        ffv_d = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d    = ST_APPLY;
                    vec_d      = vec_q + VEC_W'(1);
                    timer_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    assign busy                  = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign done                  = (state_q == ST_DONE);
    assign {dut_a, dut_b, dut_c} = busy ? vec_q : '0;
    assign pass                  = pass_q;
    assign err_count             = err_q;
    assign first_fail            = ff_q;
    assign first_fail_valid      = ffv_q;

endmodule

// File: tb/tb_xor3_bist_ctrl.sv
// Directed bench for xor3_bist_ctrl: good and faulty gate models, ignored and
// held start, asynchronous reset mid-run.
module tb_xor3_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dut_a, dut_b, dut_c;
    logic       dut_f;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_fail;
    logic       first_fail_valid;
    logic [1:0] gate_mode;
    logic [2:0] stim;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] GATE_GOOD = 2'd0;
    localparam logic [1:0] GATE_SA0  = 2'd1;
    localparam logic [1:0] GATE_NO_A = 2'd2;
    localparam logic [1:0] GATE_INV  = 2'd3;

    xor3_bist_ctrl #(
        .SETTLE_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .dut_a            (dut_a),
        .dut_b            (dut_b),
        .dut_c            (dut_c),
        .dut_f            (dut_f),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail       (first_fail),
        .first_fail_valid (first_fail_valid)
    );

    assign stim = {dut_a, dut_b, dut_c};

    // External gate: a correct my_xor or one of the planted faults.
    always_comb begin
        dut_f = 1'b0;
        case (gate_mode)
            GATE_GOOD: dut_f = dut_a ^ dut_b ^ dut_c;
            GATE_SA0:  dut_f = 1'b0;
            GATE_NO_A: dut_f = dut_b ^ dut_c;
            GATE_INV:  dut_f = ~(dut_a ^ dut_b ^ dut_c);
            default:   dut_f = 1'b0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_results(input string tag, input logic exp_pass, input logic [3:0] exp_err,
                                      input logic [2:0] exp_ff, input logic exp_ffv);
        check({tag, " pass"}, 8'(pass), 8'(exp_pass));
        check({tag, " err_count"}, 8'(err_count), 8'(exp_err));
        check({tag, " first_fail"}, 8'(first_fail), 8'(exp_ff));
        check({tag, " first_fail_valid"}, 8'(first_fail_valid), 8'(exp_ffv));
    endtask

    // Entered on a falling edge with start to be accepted at the next rising edge.
    // Walks the 24 run cycles and ends on the falling edge where done is high.
    task automatic do_run(input string tag, input logic exp_pass, input logic [3:0] exp_err,
                          input logic [2:0] exp_ff, input logic exp_ffv, input bit hold, input int poke);
        start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (!hold) start = (c == poke);
            check($sformatf("%s busy c=%0d", tag, c), 8'(busy), 8'd1);
            check($sformatf("%s done c=%0d", tag, c), 8'(done), 8'd0);
            check($sformatf("%s stim c=%0d", tag, c), 8'(stim), 8'((c - 1) / 3));
            if (c == 1) begin
                check({tag, " cleared err"}, 8'(err_count), 8'd0);
                check({tag, " cleared ffv"}, 8'(first_fail_valid), 8'd0);
            end
        end
        @(negedge clk);
        check({tag, " done"}, 8'(done), 8'd1);
        check({tag, " busy at done"}, 8'(busy), 8'd0);
        check({tag, " stim at done"}, 8'(stim), 8'd0);
        check_idle_results({tag, " @done"}, exp_pass, exp_err, exp_ff, exp_ffv);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        gate_mode = GATE_GOOD;
        repeat (2) @(negedge clk);
        check("reset busy", 8'(busy), 8'd0);
        check("reset done", 8'(done), 8'd0);
        check("reset stim", 8'(stim), 8'd0);
        check_idle_results("reset", 1'b0, 4'd0, 3'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 8'(busy), 8'd0);

        // Good gate: pass, no errors, then results hold after done drops.
        do_run("good", 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("good done drop", 8'(done), 8'd0);
        check_idle_results("good hold", 1'b1, 4'd0, 3'd0, 1'b0);

        // Stuck-at-0: mismatches on 1,2,4,7.
        gate_mode = GATE_SA0;
        do_run("sa0", 1'b0, 4'd4, 3'b001, 1'b1, 1'b0, 0);
        @(negedge clk);

        // Missing a term: mismatches on 4..7.
        gate_mode = GATE_NO_A;
        do_run("no_a", 1'b0, 4'd4, 3'b100, 1'b1, 1'b0, 0);
        @(negedge clk);

        // Inverted output: all eight mismatch, count must read 8 without wrapping.
        gate_mode = GATE_INV;
        do_run("inv", 1'b0, 4'd8, 3'b000, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("inv hold err_count", 8'(err_count), 8'd8);

        // Start pulsed during APPLY of vector 3 is ignored: exactly one done.
        gate_mode = GATE_GOOD;
        do_run("poke", 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("poke no rerun busy %0d", i), 8'(busy), 8'd0);
            check($sformatf("poke no rerun done %0d", i), 8'(done), 8'd0);
        end

        // Held start: runs every 26 cycles, each clearing the previous results.
        gate_mode = GATE_SA0;
        do_run("held1", 1'b0, 4'd4, 3'b001, 1'b1, 1'b1, 0);
        @(negedge clk);
        check("held gap busy", 8'(busy), 8'd0);
        check("held gap done", 8'(done), 8'd0);
        check("held gap err", 8'(err_count), 8'd4);
        gate_mode = GATE_GOOD;
        do_run("held2", 1'b1, 4'd0, 3'd0, 1'b0, 1'b1, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("held end busy", 8'(busy), 8'd0);
        check("held end done", 8'(done), 8'd0);
        check("held end pass", 8'(pass), 8'd1);

        // Asynchronous reset in CHECK of vector 5, with errors already recorded.
        gate_mode = GATE_SA0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        check("pre-reset stim", 8'(stim), 8'd5);
        check("pre-reset err", 8'(err_count), 8'd3);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 8'(busy), 8'd0);
        check("async rst done", 8'(done), 8'd0);
        check("async rst stim", 8'(stim), 8'd0);
        check_idle_results("async rst", 1'b0, 4'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        gate_mode = GATE_GOOD;
        @(negedge clk);
        do_run("post_rst", 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("post_rst done drop", 8'(done), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
